lector_salidas: RTL and testbench
=================================

LECTOR_SALIDAS -- requirements
Module: lector_salidas

Interface
REQ-001 Parameter FIFO_WORD_SIZE, default 10, width of one output-FIFO word; bits [9:8] are the destination field.
REQ-002 Parameter NUM_PORTS, default 4, number of output FIFOs drained (fixed at 4 for this revision).
REQ-003 Parameter CNT_WIDTH, default 5, width of each per-port word counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = drain FIFOs; 0 = stop issuing pops.
REQ-007 FIFO_empty  input  4  per-port empty flag from output FIFOs 0..3.
REQ-008 data_out0..data_out3  input  FIFO_WORD_SIZE each  FIFO read data, valid the cycle after its pop.
REQ-009 pop_FIFO_out0..pop_FIFO_out3  output  1 each  pop strobes, at most one high per cycle.
REQ-010 word_out  output  FIFO_WORD_SIZE  last word captured.
REQ-011 word_valid  output  1  one-cycle strobe qualifying word_out.
REQ-012 word_port  output  2  port index of word_out.
REQ-013 dest_error  output  1  sticky; captured word's dest field did not equal its port index.
REQ-014 req  input  1  counter query request.
REQ-015 idx  input  2  port index queried.
REQ-016 data  output  CNT_WIDTH  count of words captured from port idx.
REQ-017 valid  output  1  qualifies data.

Function
REQ-018 FSM states IDLE, DRAIN; IDLE->DRAIN when enable=1; DRAIN->IDLE when enable=0 (any capture already in flight still completes).
REQ-019 In DRAIN, each cycle, pop exactly one non-empty port, chosen round-robin starting after the last port popped; no pop if all FIFO_empty=1.
REQ-020 Never pop a port whose FIFO_empty=1 in that cycle.
REQ-021 Pop in cycle N -> capture data_out of that port at edge N+1; word_out/word_port/word_valid registered, valid during cycle N+2 (fixed 2-cycle pop-to-strobe latency).
REQ-022 Back-to-back pops on consecutive cycles yield consecutive word_valid strobes, no bubbles.
REQ-023 On capture, counter[word_port] increments by 1, saturating at 2^CNT_WIDTH-1 (31).
REQ-024 On capture, if word_out[9:8] != word_port, set dest_error; it clears only on reset.
REQ-025 req=1 in cycle N -> data=counter[idx] sampled at edge N and valid=1 in cycle N+1; req=0 -> valid=0, data=0.
REQ-026 A query in the same cycle as a capture to that counter returns the pre-increment value.
REQ-027 Counters are not cleared by enable=0; only reset clears them.
REQ-028 Round-robin pointer after reset points so that port 0 has highest priority.

Reset
REQ-029 With reset=1 at a clock edge: state=IDLE, all pops=0, word_out=0, word_valid=0, word_port=0, dest_error=0, counters=0, data=0, valid=0, RR pointer=3.
REQ-030 Reset asserted mid-drain discards any in-flight capture; no word_valid and no counter increment follows it.

Structure
REQ-031 FSM state encoding, NUM_PORTS, CNT_WIDTH and destination-field bit positions live in the shared transaction-layer package.
REQ-032 Round-robin arbiter is a separate sub-module, arbitro_rr (4 request in, one-hot grant out, pointer update on grant).

Verification
REQ-033 Port 0 loaded with 0x0A6,0x000,0x0CC, enable=1 -> three consecutive pops, word_out 0x0A6,0x000,0x0CC with word_port=0, strobes 2 cycles after each pop; req idx=0 -> data=3.
REQ-034 All four ports non-empty -> pops in order 0,1,2,3,0...; one pop per cycle.
REQ-035 Port 1 receives word 0x2A6 -> dest_error=1 and stays 1 until reset.
REQ-036 40 words through port 3 -> req idx=3 returns 31 (saturated).
REQ-037 req during the capture cycle of port 2 (count 4->5) -> data=4 next cycle; next query -> 5.
REQ-038 reset asserted one cycle after a pop -> no word_valid, counters 0, outputs per REQ-029.

Source files
------------

// File: rtl/lector_salidas_pkg.sv
// lector_salidas_pkg: shared FSM encoding, port/counter sizing and destination-field position
package lector_salidas_pkg;
    typedef enum logic {IDLE, DRAIN} state_t;
    localparam int NUM_PORTS = 4;
    localparam int CNT_WIDTH = 5;
    localparam int PORT_W = 2;
    localparam int DEST_MSB = 9;
    localparam int DEST_LSB = 8;
endpackage

// File: rtl/lector_salidas_arbitro.sv
// arbitro_rr: round-robin one-hot grant over the non-empty ports, pointer moves to the granted port
module arbitro_rr
    import lector_salidas_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        req,
    output logic [3:0]        gnt,
    output logic [PORT_W-1:0] gnt_idx
);
    logic [PORT_W-1:0] ptr_q, ptr_d, p;
    always_comb begin
        gnt = '0;
        gnt_idx = ptr_q;
        p = '0;
        // walk from farthest to nearest so the port right after ptr_q wins
        for (int i = NUM_PORTS; i >= 1; i--) begin
            p = ptr_q + PORT_W'(i);
            if (en && req[p]) begin
                gnt = 4'b0001 << p;
                gnt_idx = p;
            end
        end
        ptr_d = |gnt ? gnt_idx : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= PORT_W'(NUM_PORTS - 1);
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/lector_salidas.sv
// lector_salidas: drains four output FIFOs round-robin, strobes each word out and keeps per-port counts
module lector_salidas #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int NUM_PORTS = lector_salidas_pkg::NUM_PORTS,
    parameter int CNT_WIDTH = lector_salidas_pkg::CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [3:0]                FIFO_empty,
    input  logic [FIFO_WORD_SIZE-1:0] data_out0,
    input  logic [FIFO_WORD_SIZE-1:0] data_out1,
    input  logic [FIFO_WORD_SIZE-1:0] data_out2,
    input  logic [FIFO_WORD_SIZE-1:0] data_out3,
    output logic                      pop_FIFO_out0,
    output logic                      pop_FIFO_out1,
    output logic                      pop_FIFO_out2,
    output logic                      pop_FIFO_out3,
    output logic [FIFO_WORD_SIZE-1:0] word_out,
    output logic                      word_valid,
    output logic [1:0]                word_port,
    output logic                      dest_error,
    input  logic                      req,
    input  logic [1:0]                idx,
    output logic [CNT_WIDTH-1:0]      data,
    output logic                      valid
);
    import lector_salidas_pkg::*;
    state_t state_q, state_d;
    logic pend_q, pend_d;
    logic [1:0] pend_port_q, pend_port_d;
    logic [FIFO_WORD_SIZE-1:0] word_q, word_d, rd_word;
    logic word_valid_q, word_valid_d;
    logic [1:0] word_port_q, word_port_d;
    logic dest_error_q, dest_error_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic drain;
    // pops stay combinational on FIFO_empty so an emptying FIFO is never popped twice
    assign drain = (state_q == DRAIN) && enable;
    arbitro_rr u_arb (
        .clk(clk),
        .reset(reset),
        .en(drain),
        .req(~FIFO_empty),
        .gnt(gnt),
        .gnt_idx(gnt_idx)
    );
    assign {pop_FIFO_out3, pop_FIFO_out2, pop_FIFO_out1, pop_FIFO_out0} = gnt;
    assign word_out = word_q;
    assign word_valid = word_valid_q;
    assign word_port = word_port_q;
    assign dest_error = dest_error_q;
    assign data = data_q;
    assign valid = valid_q;
    always_comb begin
        state_d = enable ? DRAIN : IDLE;
        pend_d = |gnt;
        pend_port_d = gnt_idx;
        rd_word = pend_port_q == 2'd0 ? data_out0 :
                  pend_port_q == 2'd1 ? data_out1 :
                  pend_port_q == 2'd2 ? data_out2 : data_out3;
        word_valid_d = pend_q;
        word_d = pend_q ? rd_word : word_q;
        word_port_d = pend_q ? pend_port_q : word_port_q;
        dest_error_d = dest_error_q | (pend_q && rd_word[DEST_MSB:DEST_LSB] != pend_port_q);
        cnt_d = cnt_q;
        if (pend_q && cnt_q[pend_port_q] != '1)
            cnt_d[pend_port_q] = cnt_q[pend_port_q] + CNT_WIDTH'(1);
        valid_d = req;
        data_d = req ? cnt_q[idx] : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q <= 1'b0;
            pend_port_q <= '0;
            word_q <= '0;
            word_valid_q <= 1'b0;
            word_port_q <= '0;
            dest_error_q <= 1'b0;
            cnt_q <= '{default: '0};
            data_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            pend_port_q <= pend_port_d;
            word_q <= word_d;
            word_valid_q <= word_valid_d;
            word_port_q <= word_port_d;
            dest_error_q <= dest_error_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_lector_salidas.sv
// tb_lector_salidas: directed vectors against four behavioural output FIFOs
module tb_lector_salidas;
    logic clk = 1'b0;
    logic reset, enable, req;
    logic [1:0] idx;
    logic [3:0] FIFO_empty;
    logic [9:0] dout [4];
    logic pop0, pop1, pop2, pop3;
    logic [9:0] word_out;
    logic word_valid, dest_error, valid;
    logic [1:0] word_port;
    logic [4:0] data;
    logic [3:0] pops;
    logic [9:0] mem [4][64];
    int wr [4] = '{default: 0};
    int rd [4] = '{default: 0};
    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_w [8] = '{10'h011, 10'h121, 10'h231, 10'h341, 10'h012, 10'h122, 10'h232, 10'h342};

    always #5 clk = ~clk;

    lector_salidas dut (
        .clk(clk), .reset(reset), .enable(enable), .FIFO_empty(FIFO_empty),
        .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
        .pop_FIFO_out0(pop0), .pop_FIFO_out1(pop1), .pop_FIFO_out2(pop2), .pop_FIFO_out3(pop3),
        .word_out(word_out), .word_valid(word_valid), .word_port(word_port),
        .dest_error(dest_error), .req(req), .idx(idx), .data(data), .valid(valid)
    );

    assign pops = {pop3, pop2, pop1, pop0};

    always_comb for (int i = 0; i < 4; i++) FIFO_empty[i] = (rd[i] == wr[i]);

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (pops[i]) begin
                dout[i] <= mem[i][rd[i]];
                rd[i] <= rd[i] + 1;
            end

    task automatic push(input int p, input logic [9:0] w);
        mem[p][wr[p]] = w;
        wr[p] = wr[p] + 1;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dout[i] = '0;
        reset = 1'b1; enable = 1'b0; req = 1'b0; idx = 2'd0;
        step; step;
        chk("rst_pops", 32'(pops), 32'h0);
        chk("rst_wvalid", 32'(word_valid), 32'h0);
        chk("rst_word", 32'(word_out), 32'h0);
        chk("rst_port", 32'(word_port), 32'h0);
        chk("rst_derr", 32'(dest_error), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        reset = 1'b0;
        step;
        // three words through port 0, fixed two-cycle pop-to-strobe
        push(0, 10'h0A6); push(0, 10'h000); push(0, 10'h0CC);
        enable = 1'b1;
        step; chk("p0_pop_a", 32'(pops), 32'h1); chk("p0_wv_a", 32'(word_valid), 32'h0);
        step; chk("p0_pop_b", 32'(pops), 32'h1); chk("p0_wv_b", 32'(word_valid), 32'h0);
        step; chk("p0_pop_c", 32'(pops), 32'h1); chk("p0_wv_c", 32'(word_valid), 32'h1);
        chk("p0_w0", 32'(word_out), 32'h0A6); chk("p0_port0", 32'(word_port), 32'h0);
        step; chk("p0_pop_d", 32'(pops), 32'h0); chk("p0_wv_d", 32'(word_valid), 32'h1);
        chk("p0_w1", 32'(word_out), 32'h000);
        step; chk("p0_wv_e", 32'(word_valid), 32'h1); chk("p0_w2", 32'(word_out), 32'h0CC);
        chk("p0_port2", 32'(word_port), 32'h0);
        step; chk("p0_wv_f", 32'(word_valid), 32'h0);
        req = 1'b1; idx = 2'd0;
        step; chk("q0_valid", 32'(valid), 32'h1); chk("q0_data", 32'(data), 32'd3);
        req = 1'b0;
        step; chk("q_idle_valid", 32'(valid), 32'h0); chk("q_idle_data", 32'(data), 32'h0);
        // reset one cycle after a pop kills the in-flight capture
        push(1, 10'h100);
        #1 chk("rm_pop", 32'(pops), 32'h2);
        step; chk("rm_wv_pre", 32'(word_valid), 32'h0);
        reset = 1'b1; enable = 1'b0;
        step;
        chk("rm_pops", 32'(pops), 32'h0); chk("rm_wv", 32'(word_valid), 32'h0);
        chk("rm_word", 32'(word_out), 32'h0); chk("rm_port", 32'(word_port), 32'h0);
        chk("rm_derr", 32'(dest_error), 32'h0);
        reset = 1'b0;
        step; chk("rm_wv_post", 32'(word_valid), 32'h0);
        req = 1'b1; idx = 2'd0;
        step; chk("rm_q0_valid", 32'(valid), 32'h1); chk("rm_q0_data", 32'(data), 32'd0);
        idx = 2'd1;
        step; chk("rm_q1_data", 32'(data), 32'd0);
        req = 1'b0;
        // all ports loaded: round-robin from port 0 after reset
        for (int p = 0; p < 4; p++) begin
            push(p, exp_w[p]);
            push(p, exp_w[p + 4]);
        end
        enable = 1'b1;
        for (int k = 0; k < 11; k++) begin
            step;
            chk($sformatf("rr_pop%0d", k), 32'(pops), k < 8 ? 32'h1 << (k % 4) : 32'h0);
            chk($sformatf("rr_wv%0d", k), 32'(word_valid), (k >= 2 && k < 10) ? 32'h1 : 32'h0);
            if (k >= 2 && k < 10) begin
                chk($sformatf("rr_word%0d", k), 32'(word_out), 32'(exp_w[k - 2]));
                chk($sformatf("rr_port%0d", k), 32'(word_port), 32'((k - 2) % 4));
            end
        end
        // port 2 at count 2: three more words, query lands in the 4->5 capture cycle
        push(2, 10'h233); push(2, 10'h234); push(2, 10'h235);
        #1 chk("p2_pop", 32'(pops), 32'h4);
        step; step; step;
        req = 1'b1; idx = 2'd2;
        step; chk("p2_q_pre", 32'(data), 32'd4); chk("p2_q_valid", 32'(valid), 32'h1);
        chk("p2_last_word", 32'(word_out), 32'h235);
        step; chk("p2_q_post", 32'(data), 32'd5);
        req = 1'b0;
        // port 1 word with destination 2
        chk("de_before", 32'(dest_error), 32'h0);
        push(1, 10'h2A6);
        step; step;
        chk("de_wv", 32'(word_valid), 32'h1); chk("de_word", 32'(word_out), 32'h2A6);
        chk("de_port", 32'(word_port), 32'h1); chk("de_set", 32'(dest_error), 32'h1);
        step; step;
        chk("de_sticky", 32'(dest_error), 32'h1);
        // 40 words through port 3 saturate its counter
        for (int k = 0; k < 40; k++) push(3, 10'h300 | 10'(k));
        repeat (45) step;
        chk("sat_drained", 32'(FIFO_empty), 32'hF);
        enable = 1'b0;
        step;
        req = 1'b1; idx = 2'd3;
        step; chk("sat_q3", 32'(data), 32'd31);
        idx = 2'd0;
        step; chk("keep_q0", 32'(data), 32'd2);
        idx = 2'd1;
        step; chk("keep_q1", 32'(data), 32'd3);
        req = 1'b0;
        chk("de_still", 32'(dest_error), 32'h1);
        // enable low: a waiting word is not popped
        push(0, 10'h001);
        #1 chk("dis_pop_a", 32'(pops), 32'h0);
        step; chk("dis_pop_b", 32'(pops), 32'h0);
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("fin_derr", 32'(dest_error), 32'h0);
        req = 1'b1; idx = 2'd3;
        step; chk("fin_q3", 32'(data), 32'd0);
        req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
